text_overlay_16x1: RTL and testbench
====================================

TEXT_OVERLAY_16X1 -- requirements
Module: text_overlay_16x1

Interface -- parameters
REQ-001 ORIGIN_X, 192, left pixel column of the 16-char text box.
REQ-002 ORIGIN_Y, 224, top pixel row of the text box.
REQ-003 BLINK_FRAMES, 30, frames per blink half-period; legal range 1..127.
REQ-004 FG_RGB, 12'hFFF, colour driven on text_rgb for lit text pixels.

Interface -- ports
REQ-005 clk  input  1  system clock; every register clocks on its rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 pixel_tick  input  1  one-clk pulse marking a new pixel from the VGA sync stage.
REQ-008 video_on  input  1  sync-stage visible-area flag.
REQ-009 pixel_x, pixel_y  input  10 each  current pixel coordinates.
REQ-010 show  input  1  1 enables the overlay.
REQ-011 blink_en  input  1  1 enables blinking.
REQ-012 char_xy  output  8  combinational address to the 16x1 char ROM.
REQ-013 char_code  input  7  ASCII code returned combinationally by the char ROM.
REQ-014 font_addr  output  11  registered address to the synchronous font ROM, {char_code, row[3:0]}.
REQ-015 font_word  input  8  font ROM data, valid 1 clk after font_addr; bit 7 is the leftmost pixel.
REQ-016 text_on  output  1  registered; 1 when the current pixel is a lit text pixel.
REQ-017 text_rgb  output  12  registered; FG_RGB when text_on=1, else 12'h000.

Function
REQ-018 Geometry: 8x16 glyphs at 2x scale; the box is 256x32 pixels.
REQ-019 Offsets: dx = pixel_x-ORIGIN_X, dy = pixel_y-ORIGIN_Y.
REQ-020 in_box = (ORIGIN_X <= pixel_x < ORIGIN_X+256) and (ORIGIN_Y <= pixel_y < ORIGIN_Y+32).
REQ-021 Field extraction: col = dx[8:1], char index = col[7:3], bit = col[2:0], row = dy[4:1].
REQ-022 char_xy = {4'h0, char index[3:0]}; when in_box=0, char_xy = 8'h00.
REQ-023 Stage 1 registers font_addr, bit, in_box and video_on on every clk; the pipeline is free-running.
REQ-024 Stage 2 registers bit, in_box and video_on in step with the font ROM read.
REQ-025 Stage 3 sets text_on = font_word[7-bit] & in_box & video_on & show & visible.
REQ-026 Latency from pixel_x/pixel_y to text_on/text_rgb is exactly 3 clk.
REQ-027 Frame detection: frame_tick = pixel_tick & (pixel_x==0) & (pixel_y==0).
REQ-028 Blink counter counts 0..2*BLINK_FRAMES-1, increments on each frame_tick, and wraps to 0.
REQ-029 visible = 1 when blink_en=0 or count < BLINK_FRAMES; otherwise visible = 0.
REQ-030 When blink_en falls, the counter holds its value; visible is immediately 1.
REQ-031 show=0 forces text_on=0 with the same 3-clk alignment; the blink counter keeps running.
REQ-032 Pixels at x = ORIGIN_X+256 or y = ORIGIN_Y+32 are outside the box (exclusive upper bounds).

Reset
REQ-033 While reset_n=0, all pipeline registers, text_on, text_rgb, font_addr and the blink counter are 0.
REQ-034 A reset during any frame discards in-flight pixels.
REQ-035 After reset deassertion, the first valid text_on follows 3 clk after the first sampled pixel.
REQ-036 After reset the blink counter restarts at 0 (visible phase).

Structure
REQ-037 The shared pong_defs package holds CHAR_W=8, CHAR_H=16, TEXT_SCALE=2, TEXT_COLS=16 and the 12-bit colour constants.
REQ-038 Blink logic is one sub-module, text_blink_counter (inputs clk, reset_n, frame_tick, blink_en; output visible).
REQ-039 The char ROM and font ROM are external instances and are not contained in this block.

Verification
REQ-040 Pixel (192,224), char_code=0x53, font_word=8'h80 -> char_xy=8'h00, font_addr=11'h530 after 1 clk, text_on=1 and text_rgb=12'hFFF after 3 clk.
REQ-041 Pixel (447,255), char_code=0x45 -> char_xy=8'h0F, font_addr=11'h45F; with font_word=8'h01, text_on=1; with font_word=8'hFE, text_on=0.
REQ-042 Pixels (448,224), (191,224) and (192,256) with font_word=8'hFF -> text_on=0 and text_rgb=12'h000.
REQ-043 blink_en=1, BLINK_FRAMES=30, 60 frame_ticks -> text_on enabled for frames 0-29, suppressed for frames 30-59, enabled again at frame 60.
REQ-044 Assert reset_n=0 mid-box while text_on=1 -> text_on, font_addr and the blink counter read 0 immediately (asynchronously); after release, output resumes 3 clk after the next pixel.
REQ-045 show toggles 1->0 at clk n -> the last lit pixel appears at clk n+2 and text_on=0 from clk n+3.

Source files
------------

// File: rtl/pong_defs.sv
// pong_defs: shared text geometry, colour constants and pixel-pipeline types.
package pong_defs;
  localparam int CHAR_W     = 8;
  localparam int CHAR_H     = 16;
  localparam int TEXT_SCALE = 2;
  localparam int TEXT_COLS  = 16;
  localparam int BOX_W      = CHAR_W * TEXT_SCALE * TEXT_COLS;
  localparam int BOX_H      = CHAR_H * TEXT_SCALE;
  localparam logic [11:0] RGB_BLACK = 12'h000;
  localparam logic [11:0] RGB_WHITE = 12'hFFF;
  typedef struct packed {
    logic [2:0] bsel;
    logic       in_box;
    logic       vid;
    logic       show;
  } pix_t;
endpackage

// File: rtl/text_blink_counter.sv
// text_blink_counter: frame counter producing the blink visibility phase.
module text_blink_counter #(
  parameter int BLINK_FRAMES = 30
) (
  input  logic clk,
  input  logic reset_n,
  input  logic frame_tick,
  input  logic blink_en,
  output logic visible
);
  localparam logic [7:0] HALF = 8'(BLINK_FRAMES);
  localparam logic [7:0] LAST = 8'(2 * BLINK_FRAMES - 1);
  logic [7:0] cnt;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cnt <= '0;
    else if (frame_tick && blink_en) cnt <= (cnt == LAST) ? '0 : cnt + 8'd1;
  // Disabling blink freezes the count but shows text straight away.
  assign visible = !blink_en || cnt < HALF;
endmodule

// File: rtl/text_overlay_16x1.sv
// text_overlay_16x1: 16-character single-line text overlay, 2x scaled 8x16 glyphs,
// three-stage pipeline around external char and font ROMs.
module text_overlay_16x1
  import pong_defs::*;
#(
  parameter int          ORIGIN_X     = 192,
  parameter int          ORIGIN_Y     = 224,
  parameter int          BLINK_FRAMES = 30,
  parameter logic [11:0] FG_RGB       = 12'hFFF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        pixel_tick,
  input  logic        video_on,
  input  logic [9:0]  pixel_x,
  input  logic [9:0]  pixel_y,
  input  logic        show,
  input  logic        blink_en,
  output logic [7:0]  char_xy,
  input  logic [6:0]  char_code,
  output logic [10:0] font_addr,
  input  logic [7:0]  font_word,
  output logic        text_on,
  output logic [11:0] text_rgb
);
  localparam logic [9:0] X0 = 10'(ORIGIN_X);
  localparam logic [9:0] X1 = 10'(ORIGIN_X + BOX_W);
  localparam logic [9:0] Y0 = 10'(ORIGIN_Y);
  localparam logic [9:0] Y1 = 10'(ORIGIN_Y + BOX_H);
  logic [3:0] cidx, row;
  logic [2:0] bsel;
  logic       in_box, frame_tick, visible, lit;
  pix_t       s1, s2;
  // Halving the offsets undoes the 2x scale; the top bit of col selects nothing in a 16-wide box.
  assign {cidx, bsel} = 7'((pixel_x - X0) >> 1);
  assign row          = 4'((pixel_y - Y0) >> 1);
  assign in_box       = pixel_x >= X0 && pixel_x < X1 && pixel_y >= Y0 && pixel_y < Y1;
  assign char_xy      = in_box ? {4'h0, cidx} : 8'h00;
  assign frame_tick   = pixel_tick && pixel_x == 10'd0 && pixel_y == 10'd0;
  assign lit          = font_word[3'd7 - s2.bsel] && s2.in_box && s2.vid && s2.show && visible;
  text_blink_counter #(.BLINK_FRAMES(BLINK_FRAMES)) u_blink (
    .clk(clk), .reset_n(reset_n), .frame_tick(frame_tick), .blink_en(blink_en), .visible(visible)
  );
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      font_addr <= '0;
      s1        <= '0;
      s2        <= '0;
      text_on   <= 1'b0;
      text_rgb  <= RGB_BLACK;
    end else begin
      font_addr <= {char_code, row};
      s1        <= '{bsel: bsel, in_box: in_box, vid: video_on, show: show};
      s2        <= s1;
      text_on   <= lit;
      text_rgb  <= lit ? FG_RGB : RGB_BLACK;
    end
endmodule

// File: tb/tb_text_overlay_16x1.sv
// tb_text_overlay_16x1: scoreboard bench with behavioural ROMs and text/blink reference model.
module tb_text_overlay_16x1;
  localparam int OX = 192;
  localparam int OY = 224;
  localparam int BF = 30;

  logic        clk = 1'b0, reset_n = 1'b0, pixel_tick = 1'b0, video_on = 1'b0;
  logic [9:0]  pixel_x = '0, pixel_y = '0;
  logic        show = 1'b0, blink_en = 1'b0;
  logic [7:0]  char_xy;
  logic [6:0]  char_code;
  logic [10:0] font_addr;
  logic [7:0]  font_word = '0;
  logic        text_on;
  logic [11:0] text_rgb;

  logic [6:0]  chars [16];
  logic        alt = 1'b0;
  int          cnt_m = 0;
  logic        exp_q [$];
  int          n_checks = 0, n_fail = 0;

  text_overlay_16x1 dut (
    .clk(clk), .reset_n(reset_n), .pixel_tick(pixel_tick), .video_on(video_on),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .show(show), .blink_en(blink_en),
    .char_xy(char_xy), .char_code(char_code), .font_addr(font_addr),
    .font_word(font_word), .text_on(text_on), .text_rgb(text_rgb)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] font(input logic [6:0] c, input logic [3:0] r);
    if (c == 7'h53 && r == 4'd0) return 8'h80;
    if (c == 7'h45 && r == 4'd15) return alt ? 8'hFE : 8'h01;
    if (c == 7'h7F) return 8'hFF;
    return 8'((int'(c) * 29 + int'(r) * 53) ^ (int'(r) << 4));
  endfunction

  // External ROMs: char ROM is combinational, font ROM has one clock of latency.
  assign char_code = chars[char_xy[3:0]];
  always @(posedge clk) font_word <= font(font_addr[10:4], font_addr[3:0]);

  function automatic logic expect_on(input int x, input int y, input bit sh, input bit vo);
    int ci, gx, gy;
    logic [7:0] w;
    if (x < OX || x >= OX + 256 || y < OY || y >= OY + 32 || !sh || !vo) return 1'b0;
    if (blink_en && cnt_m >= BF) return 1'b0;
    ci = (x - OX) / 16;
    gx = ((x - OX) / 2) % 8;
    gy = (y - OY) / 2;
    w = font(chars[ci], 4'(gy));
    return w[7 - gx];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    logic e;
    #1;
    if (exp_q.size() == 3) begin
      e = exp_q.pop_front();
      check("text_on", 32'(text_on), 32'(e));
      check("text_rgb", 32'(text_rgb), e ? 32'hFFF : 32'h0);
    end
  end

  task automatic drive(input int x, input int y, input bit sh = 1'b1, input bit vo = 1'b1,
                       input bit tick = 1'b0);
    @(negedge clk);
    pixel_x = 10'(x); pixel_y = 10'(y); show = sh; video_on = vo; pixel_tick = tick;
    if (tick && x == 0 && y == 0 && blink_en) cnt_m = (cnt_m == 2 * BF - 1) ? 0 : cnt_m + 1;
    exp_q.push_back(expect_on(x, y, sh, vo));
  endtask

  task automatic fill(input int n);
    for (int i = 0; i < n; i++) drive(0, 0);
  endtask

  task automatic frame();
    fill(2);
    drive(0, 0, 1'b1, 1'b1, 1'b1);
  endtask

  task automatic set_blink(input logic b);
    fill(3);
    blink_en = b;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) chars[i] = 7'(i + 8'h41);
    repeat (3) @(negedge clk);
    check("reset text_on", 32'(text_on), 0);
    check("reset font_addr", 32'(font_addr), 0);
    check("reset text_rgb", 32'(text_rgb), 0);
    reset_n = 1'b1;
    fill(3);
    chars[0] = 7'h53;
    drive(OX, OY);
    #1 check("char_xy origin", 32'(char_xy), 32'h00);
    @(posedge clk); #1 check("font_addr origin", 32'(font_addr), 32'h530);
    fill(3);
    chars[15] = 7'h45;
    drive(447, 255);
    #1 check("char_xy far corner", 32'(char_xy), 32'h0F);
    @(posedge clk); #1 check("font_addr far corner", 32'(font_addr), 32'h45F);
    fill(3);
    alt = 1'b1;
    drive(447, 255);
    fill(3);
    chars[0] = 7'h7F;
    chars[15] = 7'h7F;
    drive(448, 224); drive(191, 224); drive(192, 256); drive(192, 255); drive(447, 224);
    fill(3);
    chars[0] = 7'h53;
    set_blink(1'b1);
    for (int f = 0; f < 65; f++) begin
      frame();
      drive(OX, OY);
    end
    for (int f = 0; f < 30; f++) frame();
    drive(OX, OY);
    set_blink(1'b0);
    drive(OX, OY);
    frame(); frame(); frame();
    drive(OX, OY);
    set_blink(1'b1);
    drive(OX, OY);
    set_blink(1'b0);
    repeat (4) drive(OX, OY, 1'b1);
    repeat (4) drive(OX, OY, 1'b0);
    repeat (4) drive(OX, OY, 1'b1);
    set_blink(1'b1);
    fill(3);
    for (int i = 0; i < 16; i++) chars[i] = 7'($urandom);
    for (int n = 0; n < 500; n++) begin
      if (n % 60 == 59) frame();
      drive(180 + int'($urandom % 285), 215 + int'($urandom % 50),
            ($urandom % 8) != 0, ($urandom % 8) != 0, 1'($urandom));
    end
    set_blink(1'b0);
    fill(3);
    chars[0] = 7'h53;
    repeat (5) drive(OX, OY);
    @(negedge clk); #2;
    check("text_on before reset", 32'(text_on), 1);
    reset_n = 1'b0;
    exp_q.delete();
    cnt_m = 0;
    #1;
    check("async text_on", 32'(text_on), 0);
    check("async text_rgb", 32'(text_rgb), 0);
    check("async font_addr", 32'(font_addr), 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    blink_en = 1'b1;
    drive(OX, OY);
    drive(OX, OY);
    for (int f = 0; f < 31; f++) begin
      frame();
      drive(OX, OY);
    end
    fill(4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
